// File: rtl/udc_seq_ctrl.sv
// rtl/udc_seq_ctrl.sv - job sequencer that programs, verifies, starts and supervises the up/down counter
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         job handshake; cmd_plr/ulr/llr/ccr carry the job
//   abort                       terminate the current job
//   ncs/nwr/nrd, A1/A0          counter bus strobes (active low) and register address
//   bus_wdata/bus_oe            write data and its drive enable; bus_rdata is read data
//   start                       counter start pulse; ctr_ec/ctr_err are counter results
//   done/status/run_cycles      completion pulse, result code, RUN cycle count
//   busy                        high whenever not IDLE
`timescale 1ns/1ps

module udc_seq_ctrl #(
    parameter bit          VERIFY  = 1'b1,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_plr,
    input  logic [7:0]  cmd_ulr,
    input  logic [7:0]  cmd_llr,
    input  logic [7:0]  cmd_ccr,
    input  logic        abort,
    output logic        ncs,
    output logic        nwr,
    output logic        nrd,
    output logic        A1,
    output logic        A0,
    output logic [7:0]  bus_wdata,
    output logic        bus_oe,
    input  logic [7:0]  bus_rdata,
    output logic        start,
    input  logic        ctr_ec,
    input  logic        ctr_err,
    output logic        done,
    output logic [2:0]  status,
    output logic [15:0] run_cycles,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_CMP   = 3'd4;
    localparam logic [2:0] S_START = 3'd5;
    localparam logic [2:0] S_RUN   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [2:0] ST_OK    = 3'd0;
    localparam logic [2:0] ST_CFG   = 3'd1;
    localparam logic [2:0] ST_VFY   = 3'd2;
    localparam logic [2:0] ST_ERR   = 3'd3;
    localparam logic [2:0] ST_TMO   = 3'd4;
    localparam logic [2:0] ST_ABORT = 3'd5;

    logic [2:0] state, state_n;
    logic [1:0] idx, idx_n;     // register index within WR/RD
    logic       gap, gap_n;     // 0 = strobe cycle, 1 = gap cycle
    logic [2:0] status_n;

    logic [7:0] plr, ulr, llr, ccr;
    logic [7:0] rb [4];         // readback, indexed by counter read address

    logic       cfg_bad, rb_ok, timeout_hit;
    logic       wr_stb_n, rd_stb_n;
    logic [7:0] wdata_n;

    assign cfg_bad     = (plr < llr) || (plr > ulr) || (ccr == 8'd0);
    // Counter read map swaps ulr/llr relative to the write map.
    assign rb_ok       = (rb[0] == plr) && (rb[1] == llr) && (rb[2] == ulr) && (rb[3] == ccr);
    // run_cycles lags the current RUN cycle by one, hence TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 16'd0) && (run_cycles == TIMEOUT - 16'd1);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        gap_n    = gap;
        status_n = status;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_n  = S_CHECK;
                    status_n = ST_OK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else if (cfg_bad) begin
                    state_n  = S_DONE;
                    status_n = ST_CFG;
                end else begin
                    state_n = S_WR;
                    idx_n   = 2'd0;
                    gap_n   = 1'b0;
                end
            end
            S_WR, S_RD: begin
                if (abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else if (!gap) begin
                    gap_n = 1'b1;
                end else if (idx == 2'd3) begin
                    idx_n = 2'd0;
                    gap_n = 1'b0;
                    if (state == S_RD)
                        state_n = S_CMP;
                    else if (VERIFY)
                        state_n = S_RD;
                    else
                        state_n = S_START;
                end else begin
                    idx_n = idx + 2'd1;
                    gap_n = 1'b0;
                end
            end
            S_CMP: begin
                if (abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else if (!rb_ok) begin
                    state_n  = S_DONE;
                    status_n = ST_VFY;
                end else begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_n  = S_DONE;
                    status_n = ST_ABORT;
                end else if (ctr_err) begin
                    state_n  = S_DONE;
                    status_n = ST_ERR;
                end else if (ctr_ec) begin
                    state_n  = S_DONE;
                    status_n = ST_OK;
                end else if (timeout_hit) begin
                    state_n  = S_DONE;
                    status_n = ST_TMO;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign wr_stb_n = (state_n == S_WR) && !gap_n;
    assign rd_stb_n = (state_n == S_RD) && !gap_n;

    always_comb begin
        wdata_n = 8'd0;
        case (idx_n)
            2'd0:    wdata_n = plr;
            2'd1:    wdata_n = ulr;
            2'd2:    wdata_n = llr;
            default: wdata_n = ccr;
        endcase
        if (!wr_stb_n)
            wdata_n = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            gap        <= 1'b0;
            status     <= ST_OK;
            run_cycles <= 16'd0;
            plr        <= 8'd0;
            ulr        <= 8'd0;
            llr        <= 8'd0;
            ccr        <= 8'd0;
            for (int i = 0; i < 4; i++)
                rb[i] <= 8'd0;
            ncs        <= 1'b1;
            nwr        <= 1'b1;
            nrd        <= 1'b1;
            A1         <= 1'b0;
            A0         <= 1'b0;
            bus_wdata  <= 8'd0;
            bus_oe     <= 1'b0;
            start      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            gap    <= gap_n;
            status <= status_n;

            if (state == S_IDLE && cmd_valid) begin
                plr        <= cmd_plr;
                ulr        <= cmd_ulr;
                llr        <= cmd_llr;
                ccr        <= cmd_ccr;
                run_cycles <= 16'd0;
            end

            if (state == S_RUN && run_cycles != 16'hFFFF)
                run_cycles <= run_cycles + 16'd1;

            if (state == S_RD && !gap)
                rb[idx] <= bus_rdata;

            ncs       <= !(wr_stb_n || rd_stb_n);
            nwr       <= !wr_stb_n;
            nrd       <= !rd_stb_n;
            A1        <= (wr_stb_n || rd_stb_n) ? idx_n[1] : 1'b0;
            A0        <= (wr_stb_n || rd_stb_n) ? idx_n[0] : 1'b0;
            bus_wdata <= wdata_n;
            bus_oe    <= wr_stb_n;
            start     <= (state_n == S_START);
            done      <= (state_n == S_DONE);
            busy      <= (state_n != S_IDLE);
            cmd_ready <= (state_n == S_IDLE);
        end
    end

endmodule

// File: tb/tb_udc_seq_ctrl.sv
// tb/tb_udc_seq_ctrl.sv - scoreboard bench for udc_seq_ctrl
`timescale 1ns/1ps

module tb_udc_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       abort = 1'b0, ctr_ec = 1'b0, ctr_err = 1'b0;
    logic [7:0] cmd_plr = 8'd0, cmd_ulr = 8'd0, cmd_llr = 8'd0, cmd_ccr = 8'd0;

    logic        cmd_valid_a = 1'b0, cmd_ready_a;
    logic        ncs_a, nwr_a, nrd_a, A1_a, A0_a, bus_oe_a, start_a, done_a, busy_a;
    logic [7:0]  bus_wdata_a, bus_rdata_a;
    logic [2:0]  status_a;
    logic [15:0] run_cycles_a;

    logic        cmd_valid_t = 1'b0, cmd_ready_t;
    logic        ncs_t, nwr_t, nrd_t, A1_t, A0_t, bus_oe_t, start_t, done_t, busy_t;
    logic [7:0]  bus_wdata_t;
    logic [7:0]  bus_rdata_t = 8'd0;
    logic [2:0]  status_t;
    logic [15:0] run_cycles_t;

    udc_seq_ctrl #(.VERIFY(1'b1), .TIMEOUT(16'd4096)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_plr(cmd_plr), .cmd_ulr(cmd_ulr), .cmd_llr(cmd_llr), .cmd_ccr(cmd_ccr),
        .abort(abort), .ncs(ncs_a), .nwr(nwr_a), .nrd(nrd_a), .A1(A1_a), .A0(A0_a),
        .bus_wdata(bus_wdata_a), .bus_oe(bus_oe_a), .bus_rdata(bus_rdata_a),
        .start(start_a), .ctr_ec(ctr_ec), .ctr_err(ctr_err), .done(done_a),
        .status(status_a), .run_cycles(run_cycles_a), .busy(busy_a)
    );

    udc_seq_ctrl #(.VERIFY(1'b0), .TIMEOUT(16'd16)) dut_t (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t),
        .cmd_plr(cmd_plr), .cmd_ulr(cmd_ulr), .cmd_llr(cmd_llr), .cmd_ccr(cmd_ccr),
        .abort(abort), .ncs(ncs_t), .nwr(nwr_t), .nrd(nrd_t), .A1(A1_t), .A0(A0_t),
        .bus_wdata(bus_wdata_t), .bus_oe(bus_oe_t), .bus_rdata(bus_rdata_t),
        .start(start_t), .ctr_ec(ctr_ec), .ctr_err(ctr_err), .done(done_t),
        .status(status_t), .run_cycles(run_cycles_t), .busy(busy_t)
    );

    typedef struct { logic [2:0] st; logic [15:0] rc; int cyc; } done_exp_t;
    typedef struct { logic [1:0] ad; logic [7:0] d; int cyc; } wr_exp_t;

    done_exp_t q_done_a[$];
    done_exp_t q_done_t[$];
    wr_exp_t   q_wr[$];
    int        q_start_a[$];
    int        q_start_t[$];

    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0;
    int   strobe_cnt = 0, rd_cnt = 0, t_strobe_cnt = 0;
    logic corrupt = 1'b0;
    logic [7:0] wreg [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Counter register model: stores by write address, answers by read map.
    always @(posedge clk)
        if (ncs_a == 1'b0 && nwr_a == 1'b0 && bus_oe_a == 1'b1)
            wreg[{A1_a, A0_a}] <= bus_wdata_a;

    always_comb begin
        case ({A1_a, A0_a})
            2'b00:   bus_rdata_a = wreg[0];
            2'b01:   bus_rdata_a = corrupt ? 8'h03 : wreg[2];
            2'b10:   bus_rdata_a = wreg[1];
            default: bus_rdata_a = wreg[3];
        endcase
    end

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin : mon
        done_exp_t e;
        wr_exp_t   w;
        int        s;
        if (done_a === 1'b1) begin
            if (q_done_a.size() == 0) fail_evt("done_a_unexpected");
            else begin
                e = q_done_a.pop_front();
                chk("status_a", {29'd0, status_a}, {29'd0, e.st});
                chk("run_cycles_a", {16'd0, run_cycles_a}, {16'd0, e.rc});
                chk("done_a_cycle", cyc, e.cyc);
            end
        end
        if (done_t === 1'b1) begin
            if (q_done_t.size() == 0) fail_evt("done_t_unexpected");
            else begin
                e = q_done_t.pop_front();
                chk("status_t", {29'd0, status_t}, {29'd0, e.st});
                chk("run_cycles_t", {16'd0, run_cycles_t}, {16'd0, e.rc});
                chk("done_t_cycle", cyc, e.cyc);
            end
        end
        if (ncs_a === 1'b0) strobe_cnt++;
        if (ncs_t === 1'b0) t_strobe_cnt++;
        if (ncs_a === 1'b0 && nwr_a === 1'b0) begin
            if (q_wr.size() == 0) fail_evt("write_unexpected");
            else begin
                w = q_wr.pop_front();
                chk("wr_addr", {30'd0, A1_a, A0_a}, {30'd0, w.ad});
                chk("wr_data", {24'd0, bus_wdata_a}, {24'd0, w.d});
                chk("wr_cycle", cyc, w.cyc);
                chk("wr_oe", {31'd0, bus_oe_a}, 32'd1);
                chk("wr_nrd", {31'd0, nrd_a}, 32'd1);
            end
        end
        if (ncs_a === 1'b0 && nrd_a === 1'b0) begin
            rd_cnt++;
            chk("rd_oe", {31'd0, bus_oe_a}, 32'd0);
            chk("rd_nwr", {31'd0, nwr_a}, 32'd1);
        end
        if (start_a === 1'b1) begin
            if (q_start_a.size() == 0) fail_evt("start_a_unexpected");
            else begin
                s = q_start_a.pop_front();
                chk("start_a_cycle", cyc, s);
            end
        end
        if (start_t === 1'b1) begin
            if (q_start_t.size() == 0) fail_evt("start_t_unexpected");
            else begin
                s = q_start_t.pop_front();
                chk("start_t_cycle", cyc, s);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(cmd_ready_a === 1'b1 && cmd_ready_t === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_evt("wait_idle_timeout");
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Returns base such that spec cycle Tk is cyc == base + k.
    task automatic issue(input bit to_t, input logic [7:0] p, u, l, c, output int base);
        @(negedge clk);
        wait_idle();
        cmd_plr = p; cmd_ulr = u; cmd_llr = l; cmd_ccr = c;
        if (to_t) cmd_valid_t = 1'b1;
        else      cmd_valid_a = 1'b1;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        cmd_valid_t = 1'b0;
        base = cyc - 1;
    endtask

    task automatic push_wr(input int base, input logic [7:0] p, u, l, c, input int n);
        logic [7:0] v [4];
        v[0] = p; v[1] = u; v[2] = l; v[3] = c;
        for (int k = 0; k < n; k++)
            q_wr.push_back('{ad: k[1:0], d: v[k], cyc: base + 2 + 2 * k});
    endtask

    task automatic push_done(input bit to_t, input logic [2:0] st, input logic [15:0] rc, input int c);
        if (to_t) q_done_t.push_back('{st: st, rc: rc, cyc: c});
        else      q_done_a.push_back('{st: st, rc: rc, cyc: c});
    endtask

    task automatic pulse_at(input int n, input logic a, input logic e, input logic er);
        wait_cyc(n);
        abort = a; ctr_ec = e; ctr_err = er;
        @(negedge clk);
        abort = 1'b0; ctr_ec = 1'b0; ctr_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, r0, s0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ncs", {31'd0, ncs_a}, 32'd1);
        chk("rst_nwr", {31'd0, nwr_a}, 32'd1);
        chk("rst_nrd", {31'd0, nrd_a}, 32'd1);
        chk("rst_addr", {30'd0, A1_a, A0_a}, 32'd0);
        chk("rst_wdata", {24'd0, bus_wdata_a}, 32'd0);
        chk("rst_oe", {31'd0, bus_oe_a}, 32'd0);
        chk("rst_start", {31'd0, start_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_status", {29'd0, status_a}, 32'd0);
        chk("rst_run_cycles", {16'd0, run_cycles_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready_a}, 32'd1);
        chk("rst_cmd_ready_t", {31'd0, cmd_ready_t}, 32'd1);
        rst = 1'b0;

        // Valid job, verify, end-of-count in RUN cycle 40.
        r0 = rd_cnt;
        issue(1'b0, 8'd5, 8'd10, 8'd2, 8'd3, b);
        push_wr(b, 8'd5, 8'd10, 8'd2, 8'd3, 4);
        q_start_a.push_back(b + 19);
        push_done(1'b0, 3'd0, 16'd40, b + 60);
        pulse_at(b + 59, 1'b0, 1'b1, 1'b0);
        wait_idle();
        chk("job1_reads", rd_cnt - r0, 32'd4);

        // Invalid configurations: plr<llr, plr>ulr, ccr==0.
        s0 = strobe_cnt;
        issue(1'b0, 8'd1, 8'd10, 8'd2, 8'd3, b);
        push_done(1'b0, 3'd1, 16'd0, b + 2);
        wait_idle();
        issue(1'b0, 8'd11, 8'd10, 8'd2, 8'd3, b);
        push_done(1'b0, 3'd1, 16'd0, b + 2);
        wait_idle();
        issue(1'b0, 8'd5, 8'd10, 8'd2, 8'd0, b);
        push_done(1'b0, 3'd1, 16'd0, b + 2);
        wait_idle();
        chk("invalid_no_strobes", strobe_cnt - s0, 32'd0);

        // Readback mismatch at read address 01.
        r0 = rd_cnt;
        corrupt = 1'b1;
        issue(1'b0, 8'd5, 8'd10, 8'd2, 8'd3, b);
        push_wr(b, 8'd5, 8'd10, 8'd2, 8'd3, 4);
        push_done(1'b0, 3'd2, 16'd0, b + 19);
        wait_idle();
        corrupt = 1'b0;
        chk("vfail_reads", rd_cnt - r0, 32'd4);

        // ctr_err and ctr_ec together in RUN cycle 5.
        issue(1'b0, 8'd5, 8'd10, 8'd2, 8'd3, b);
        push_wr(b, 8'd5, 8'd10, 8'd2, 8'd3, 4);
        q_start_a.push_back(b + 19);
        push_done(1'b0, 3'd3, 16'd5, b + 25);
        pulse_at(b + 24, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // Abort during the gap after the second write.
        issue(1'b0, 8'd5, 8'd10, 8'd2, 8'd3, b);
        push_wr(b, 8'd5, 8'd10, 8'd2, 8'd3, 2);
        push_done(1'b0, 3'd5, 16'd0, b + 6);
        pulse_at(b + 5, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Reset at T7: bus idle next cycle, no done.
        issue(1'b0, 8'd5, 8'd10, 8'd2, 8'd3, b);
        push_wr(b, 8'd5, 8'd10, 8'd2, 8'd3, 3);
        wait_cyc(b + 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ncs", {31'd0, ncs_a}, 32'd1);
        chk("midrst_nwr", {31'd0, nwr_a}, 32'd1);
        chk("midrst_nrd", {31'd0, nrd_a}, 32'd1);
        chk("midrst_oe", {31'd0, bus_oe_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready_a}, 32'd1);

        // Boundary-valid job after reset, end-of-count in first RUN cycle.
        issue(1'b0, 8'd7, 8'd7, 8'd7, 8'd1, b);
        push_wr(b, 8'd7, 8'd7, 8'd7, 8'd1, 4);
        q_start_a.push_back(b + 19);
        push_done(1'b0, 3'd0, 16'd1, b + 21);
        pulse_at(b + 20, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Abort outranks ctr_err and ctr_ec in RUN cycle 3.
        issue(1'b0, 8'd0, 8'd255, 8'd0, 8'd255, b);
        push_wr(b, 8'd0, 8'd255, 8'd0, 8'd255, 4);
        q_start_a.push_back(b + 19);
        push_done(1'b0, 3'd5, 16'd3, b + 23);
        pulse_at(b + 22, 1'b1, 1'b1, 1'b1);
        wait_idle();

        // No-verify instance with TIMEOUT=16, counter never ends.
        s0 = t_strobe_cnt;
        issue(1'b1, 8'd5, 8'd10, 8'd2, 8'd3, b);
        q_start_t.push_back(b + 10);
        push_done(1'b1, 3'd4, 16'd16, b + 27);
        wait_idle();
        chk("t_strobes", t_strobe_cnt - s0, 32'd4);

        repeat (5) @(negedge clk);
        chk("left_done_a", q_done_a.size(), 32'd0);
        chk("left_done_t", q_done_t.size(), 32'd0);
        chk("left_wr", q_wr.size(), 32'd0);
        chk("left_start_a", q_start_a.size(), 32'd0);
        chk("left_start_t", q_start_t.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
